// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM states, FIFO entry layout, width decode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  // One received character as stored in the FIFO, MSB first: {break, frame_err, parity_err, data}
  typedef struct packed {
    logic       brk;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  localparam logic [1:0] DBN_5 = 2'b00;
  localparam logic [1:0] DBN_6 = 2'b01;
  localparam logic [1:0] DBN_7 = 2'b10;
  localparam logic [1:0] DBN_8 = 2'b11;

  // Index of the last data bit for a given width code.
  function automatic logic [2:0] data_bits_m1(input logic [1:0] dbn);
    case (dbn)
      DBN_5:   return 3'd4;
      DBN_6:   return 3'd5;
      DBN_7:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_core_if.sv
// Read-side bus of the receiver: FIFO pop, head entry, status and flow control.
interface uart_rx_fifo_core_if #(
  parameter int LVL_W = 5
);
  logic             rd_en_i;
  logic [7:0]       data_o;
  logic             parity_err_o;
  logic             frame_err_o;
  logic             break_o;
  logic             empty_o;
  logic             full_o;
  logic [LVL_W-1:0] level_o;
  logic             overrun_o;
  logic             rts_no;

  // Receiver side
  modport master (
    input  rd_en_i,
    output data_o, parity_err_o, frame_err_o, break_o,
    output empty_o, full_o, level_o, overrun_o, rts_no
  );

  // Consumer side
  modport slave (
    output rd_en_i,
    input  data_o, parity_err_o, frame_err_o, break_o,
    input  empty_o, full_o, level_o, overrun_o, rts_no
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: pointer pair with wrap bit, zero head when empty, overrun pulse on dropped write.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp_q, rp_q;
  logic             ovr_q;
  logic             do_rd, do_wr;

  assign level   = wp_q - rp_q;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rp_q[AW-1:0]];
  assign overrun = ovr_q;

  // Pointer and overrun bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      ovr_q <= wr_en & ~do_wr;
    end
  end

  // Storage array, no reset needed: empty masks stale contents
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo_core.sv
// UART receiver: oversampled majority-vote framing into a status-tagged receive FIFO.
module uart_rx_fifo_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_en_i,
  input  logic                tick_i,
  input  logic                rx_i,
  input  logic [1:0]          data_bit_num_i,
  input  logic                parity_en_i,
  input  logic                parity_type_i,
  input  logic                stop_bit_num_i,
  uart_rx_fifo_core_if.master rd
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] C_S0  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] C_S1  = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] C_MID = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);

  rx_state_e state_q, state_d;

  logic          rx_m, rx_s, rx_d, fall;
  logic [CW-1:0] cnt_q;
  logic [1:0]    smp_q;
  logic          at_mid, at_end, maj, last_mid, brk;
  logic [2:0]    bit_idx_q, nbits_m1_q;
  logic          par_en_q, par_type_q, two_stop_q, stop_idx_q;
  logic [7:0]    data_q;
  logic          perr_q, ferr_q, zero_q;
  logic          wr_en;
  rx_entry_t     wr_entry, head;
  logic [LW-1:0] level;
  logic          rts_q;

  assign fall     = rx_d & ~rx_s;
  assign at_mid   = tick_i && (cnt_q == C_MID);
  assign at_end   = tick_i && (cnt_q == C_END);
  // Third sample is the live line at the mid tick; the first two were captured earlier.
  assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign last_mid = at_mid && (stop_idx_q == two_stop_q);
  // In the second stop bit zero_q already includes the first stop bit.
  assign brk      = zero_q & (stop_idx_q | ~maj);

  // Two-flop synchronizer plus previous value for edge detect; idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; disabling the receiver aborts any frame in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (fall) state_d = ST_START;
      ST_START:     if (at_mid && maj) state_d = ST_IDLE;
                    else if (at_end) state_d = ST_DATA;
      ST_DATA:      if (at_end && bit_idx_q == nbits_m1_q)
                      state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (at_end) state_d = ST_STOP;
      ST_STOP:      if (last_mid) state_d = brk ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (!rx_en_i) state_d = ST_IDLE;
  end

  // FSM outputs: push the finished entry on the final stop-bit sample
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '0;
    if (state_q == ST_STOP && last_mid && rx_en_i) begin
      wr_en               = 1'b1;
      wr_entry.brk        = brk;
      wr_entry.frame_err  = ferr_q | ~maj;
      wr_entry.parity_err = perr_q;
      wr_entry.data       = data_q;
    end
  end

  // Bit timing, sampling and frame assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      smp_q      <= '0;
      bit_idx_q  <= '0;
      nbits_m1_q <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      // Held at zero in IDLE so counting starts fresh at the start edge
      if (state_q == ST_IDLE) cnt_q <= '0;
      else if (tick_i)        cnt_q <= cnt_q + 1'b1;
      if (tick_i && cnt_q == C_S0) smp_q[0] <= rx_s;
      if (tick_i && cnt_q == C_S1) smp_q[1] <= rx_s;
      case (state_q)
        ST_START: if (at_mid && !maj) begin
          nbits_m1_q <= data_bits_m1(data_bit_num_i);
          par_en_q   <= parity_en_i;
          par_type_q <= parity_type_i;
          two_stop_q <= stop_bit_num_i;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          data_q     <= '0;
          perr_q     <= 1'b0;
          ferr_q     <= 1'b0;
          zero_q     <= 1'b1;
        end
        ST_DATA: begin
          if (at_mid) begin
            data_q[bit_idx_q] <= maj;
            zero_q            <= zero_q & ~maj;
          end
          if (at_end) bit_idx_q <= bit_idx_q + 1'b1;
        end
        ST_PARITY: if (at_mid) begin
          // Even: error when data^parity is 1; odd: error when it is 0
          perr_q <= (^data_q) ^ maj ^ par_type_q;
          zero_q <= zero_q & ~maj;
        end
        ST_STOP: begin
          if (at_mid) begin
            ferr_q <= ferr_q | ~maj;
            if (!stop_idx_q) zero_q <= zero_q & ~maj;
          end
          if (at_end) stop_idx_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd.rd_en_i),
    .rd_data (head),
    .empty   (rd.empty_o),
    .full    (rd.full_o),
    .level   (level),
    .overrun (rd.overrun_o)
  );

  // Flow control: deassert request-to-send once the FIFO reaches the threshold
  always_ff @(posedge clk) begin
    if (reset) rts_q <= 1'b0;
    else       rts_q <= (level >= LW'(RTS_THRESHOLD));
  end

  assign rd.level_o      = level;
  assign rd.rts_no       = rts_q;
  assign rd.data_o       = head.data;
  assign rd.parity_err_o = head.parity_err;
  assign rd.frame_err_o  = head.frame_err;
  assign rd.break_o      = head.brk;

endmodule

// File: doc/uart_rx_fifo_core.md
UART_RX_FIFO_CORE -- requirements
Module: uart_rx_fifo_core

Interface
REQ-001 Parameter OVERSAMPLE, default 16, tick_i pulses per bit; SHALL be 8 or 16.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 Parameter RTS_THRESHOLD, default 12, FIFO level at which rts_no deasserts.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rx_en_i  in  1  receiver enable.
REQ-008 tick_i  in  1  baud tick, one clk wide, OVERSAMPLE per bit.
REQ-009 rx_i  in  1  asynchronous serial line, idle high.
REQ-010 data_bit_num_i  in  2  00/01/10/11 = 5/6/7/8 data bits.
REQ-011 parity_en_i, parity_type_i, stop_bit_num_i  in  1 each  parity enable; 0 even / 1 odd; 0 one / 1 two stop bits.
REQ-012 rd_en_i  in  1  pop FIFO head.
REQ-013 data_o  out  8  FIFO head data, unused upper bits zero.
REQ-014 parity_err_o, frame_err_o, break_o  out  1 each  flags of FIFO head entry.
REQ-015 empty_o, full_o  out  1 each  FIFO status.
REQ-016 level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 overrun_o  out  1  one-cycle pulse, frame dropped.
REQ-018 rts_no  out  1  active-low request-to-send.

Function
REQ-019 rx_i SHALL pass a 2-flop synchronizer; all logic uses the synchronized line.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-021 IDLE->START on synchronized falling edge while rx_en_i=1; the tick counter clears.
REQ-022 Each bit value SHALL be the majority of samples at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-023 START: a majority-0 result confirms the start bit -> DATA; majority-1 (glitch) -> IDLE with no FIFO write.
REQ-024 Config inputs SHALL be latched at start confirmation; later changes affect only the next frame.
REQ-025 DATA shifts LSB first, sized per latched width -> PARITY if enabled, else STOP.
REQ-026 parity_err SHALL be set when the XOR of data and parity bit is 1 for even, or 0 for odd.
REQ-027 STOP checks one or two stop bits; any low stop bit sets frame_err.
REQ-028 break SHALL be set when all data bits, any parity bit and the first stop bit are 0; the FSM then enters WAIT_IDLE, else IDLE.
REQ-029 WAIT_IDLE SHALL hold until the synchronized line is 1, then go to IDLE.
REQ-030 The FIFO write of {break, frame_err, parity_err, data} SHALL occur in the clk of the final stop-bit sample; empty_o/level_o update the next cycle.
REQ-031 A write while full with no simultaneous read SHALL be dropped and overrun_o pulsed; a write with a read while full SHALL succeed.
REQ-032 rd_en_i while empty SHALL be ignored; outputs SHALL always show the current head, zero when empty.
REQ-033 rts_no SHALL be 1 when level_o >= RTS_THRESHOLD, else 0, registered.
REQ-034 rx_en_i=0 SHALL force IDLE next cycle, discarding a partial frame; FIFO contents are retained.

Reset
REQ-035 Reset SHALL clear FSM to IDLE, counters, FIFO pointers and synchronizer flops (to 1).
REQ-036 Reset values: data_o=0, all flags 0, empty_o=1, full_o=0, level_o=0, overrun_o=0, rts_no=0.
REQ-037 Reset mid-frame SHALL discard the frame with no write.

Structure
REQ-038 Package uart_pkg SHALL hold the FSM state enum, the FIFO entry struct (break, frame_err, parity_err, data[7:0]) and data-width decode constants.
REQ-039 The FIFO SHALL be sub-module uart_rx_fifo (parameter DEPTH, WIDTH=11).

Verification
REQ-040 8N1, OVERSAMPLE=16, byte 0xA5 -> data_o=0xA5, all flags 0, level_o=1.
REQ-041 rx_i low for 4 ticks then high -> no write, FSM back to IDLE.
REQ-042 7O1, data 0x35 with even-parity bit -> data_o=0x35, parity_err_o=1.
REQ-043 17 frames of 0x00..0x10 with no reads, FIFO_DEPTH=16 -> rts_no=1 from level 12; overrun_o pulses on frame 17; level_o=16; the head reads 0x00.
REQ-044 Line held low for 2 frame times -> one entry with break_o=1, frame_err_o=1, data 0x00; no further entry until the line goes high.
REQ-045 reset asserted mid-DATA -> no entry; the next 0x3C frame is received correctly.
